crg_seq_ctrl: RTL and testbench

- Parametrised per-channel clock-enable and reset sequencer. It is the next-generation replacement for the fixed gate/reset wiring in the clock-reset unit.
- Each of N_CH channels turns a level request into an ordered sequence with an acknowledge:
  - power-up: clock on, reset held, then reset released;
  - power-down: reset asserted, clock kept running, then clock gated.
- Outputs drive the enable pin of genpart_ckgt instances and the reset inputs of downstream blocks.
- Runs on the always-on clock domain. Optional chaining enforces power-up order by index and power-down in reverse order.

---
 rtl/crg_seq_ctrl_if.sv | 31 +++
 rtl/crg_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_crg_seq_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/crg_seq_ctrl_if.sv
// Per-channel request/acknowledge bundle for the clock/reset sequencer.
// The master side drives requests and software reset pulses; the slave side
// (the sequencer) returns clock enables, resets, acknowledges and busy.
interface crg_seq_ctrl_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] req_i;
    logic [N_CH-1:0] sw_rst_i;
    logic [N_CH-1:0] clk_en_o;
    logic [N_CH-1:0] rst_n_o;
    logic [N_CH-1:0] ack_o;
    logic            busy_o;

    modport master (
        output req_i,
        output sw_rst_i,
        input  clk_en_o,
        input  rst_n_o,
        input  ack_o,
        input  busy_o
    );

    modport slave (
        input  req_i,
        input  sw_rst_i,
        output clk_en_o,
        output rst_n_o,
        output ack_o,
        output busy_o
    );
endinterface

// File: rtl/crg_seq_ctrl.sv
// Per-channel clock-enable / reset sequencer on the always-on clock.
// Power-up: clock on with reset held, then reset released. Power-down:
// reset asserted with clock running, then clock gated. Optional chaining
// orders power-up by index and power-down in reverse.
module crg_seq_ctrl #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PRE_CYC     = 4,
    parameter int POST_CYC    = 4,
    parameter int PULSE_CYC   = 2,
    parameter int CHAIN       = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic scan_mode,
    input  logic scan_rstn,
    crg_seq_ctrl_if.slave bus
);

    localparam int MAX_A = (PRE_CYC > POST_CYC) ? PRE_CYC : POST_CYC;
    localparam int MAX_C = (MAX_A > PULSE_CYC) ? MAX_A : PULSE_CYC;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] PRE_LAST   = CW'(PRE_CYC - 1);
    localparam logic [CW-1:0] POST_LAST  = CW'(POST_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_CLK_ON,
        ST_RUN,
        ST_SWRST,
        ST_RST_ON
    } state_t;

    logic [SYNC_STAGES*N_CH-1:0] sync_q;
    logic [N_CH-1:0]             reqs;
    logic [N_CH-1:0]             off_v;
    logic [N_CH-1:0]             run_v;
    logic [N_CH-1:0]             trans_v;
    logic [N_CH-1:0]             clk_en_fsm;
    logic [N_CH-1:0]             rst_n_fsm;

    // Request synchroniser: stages packed side by side, newest in the low slice.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[(SYNC_STAGES-1)*N_CH-1:0], bus.req_i};
        end
    end

    assign reqs = sync_q[SYNC_STAGES*N_CH-1 -: N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t          state_q, state_d;
        logic [CW-1:0]   cnt_q, cnt_d;
        logic            eff;
        logic            hold;

        // Chained channels wait for their predecessor to be running.
        if (CHAIN != 0 && i > 0) begin : g_eff_chain
            assign eff = reqs[i] & run_v[i-1];
        end else begin : g_eff_free
            assign eff = reqs[i];
        end

        // Chained channels may not shut down while their successor is still up.
        if (CHAIN != 0 && i < N_CH - 1) begin : g_hold
            assign hold = ~off_v[i+1];
        end else begin : g_nohold
            assign hold = 1'b0;
        end

        // Channel state and sequencing counter.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_q <= ST_OFF;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next-state and counter update; aborts take priority over completion.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                ST_OFF: begin
                    if (eff) begin
                        state_d = ST_CLK_ON;
                        cnt_d   = '0;
                    end
                end
                ST_CLK_ON: begin
                    if (!eff) begin
                        state_d = ST_RST_ON;
                        cnt_d   = '0;
                    end else if (cnt_q == PRE_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (!eff && !hold) begin
                        state_d = ST_RST_ON;
                        cnt_d   = '0;
                    end else if (bus.sw_rst_i[i]) begin
                        state_d = ST_SWRST;
                        cnt_d   = '0;
                    end
                end
                ST_SWRST: begin
                    if (!eff) begin
                        state_d = ST_RST_ON;
                        cnt_d   = '0;
                    end else if (cnt_q == PULSE_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RST_ON: begin
                    if (cnt_q == POST_LAST) begin
                        state_d = ST_OFF;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end

        assign off_v[i]      = (state_q == ST_OFF);
        assign run_v[i]      = (state_q == ST_RUN);
        assign trans_v[i]    = (state_q == ST_CLK_ON) || (state_q == ST_SWRST) ||
                               (state_q == ST_RST_ON);
        assign clk_en_fsm[i] = (state_q != ST_OFF);
        assign rst_n_fsm[i]  = (state_q == ST_RUN);
    end

    assign bus.clk_en_o = scan_mode ? '1 : clk_en_fsm;
    assign bus.rst_n_o  = scan_mode ? {N_CH{scan_rstn}} : rst_n_fsm;
    assign bus.ack_o    = run_v;
    assign bus.busy_o   = |trans_v;

endmodule

// File: tb/tb_crg_seq_ctrl.sv
// Directed bench for crg_seq_ctrl: one independent-channel instance and one
// chained instance, stepped edge by edge against hand-derived timelines.
module tb_crg_seq_ctrl;

    logic clk;
    logic rstn;
    logic scan_mode;
    logic scan_rstn;

    int nchecks = 0;
    int nerr    = 0;

    crg_seq_ctrl_if #(.N_CH(4)) bus_a ();
    crg_seq_ctrl_if #(.N_CH(4)) bus_b ();

    crg_seq_ctrl #(
        .N_CH(4), .SYNC_STAGES(2), .PRE_CYC(4), .POST_CYC(4), .PULSE_CYC(2), .CHAIN(0)
    ) u_free (
        .clk(clk), .rstn(rstn), .scan_mode(scan_mode), .scan_rstn(scan_rstn), .bus(bus_a.slave)
    );

    crg_seq_ctrl #(
        .N_CH(4), .SYNC_STAGES(2), .PRE_CYC(4), .POST_CYC(4), .PULSE_CYC(2), .CHAIN(1)
    ) u_chain (
        .clk(clk), .rstn(rstn), .scan_mode(scan_mode), .scan_rstn(scan_rstn), .bus(bus_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    // Advance n rising edges; inputs are driven and outputs sampled 1 unit after.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; scan_mode = 1'b0; scan_rstn = 1'b0;
        bus_a.req_i = '0; bus_a.sw_rst_i = '0;
        bus_b.req_i = '0; bus_b.sw_rst_i = '0;
        #1;
        nchecks++; if ({bus_a.clk_en_o, bus_a.rst_n_o, bus_a.ack_o, bus_a.busy_o} !== 13'd0) begin
            nerr++; $display("FAIL reset_a: got %b want 0", {bus_a.clk_en_o, bus_a.rst_n_o, bus_a.ack_o, bus_a.busy_o}); end
        tick(2);
        nchecks++; if ({bus_b.clk_en_o, bus_b.rst_n_o, bus_b.ack_o, bus_b.busy_o} !== 13'd0) begin
            nerr++; $display("FAIL reset_b: got %b want 0", {bus_b.clk_en_o, bus_b.rst_n_o, bus_b.ack_o, bus_b.busy_o}); end
        rstn = 1'b1;
        tick(2);
        nchecks++; if (bus_a.clk_en_o !== 4'b0000) begin
            nerr++; $display("FAIL post_reset_idle: got %b want 0000", bus_a.clk_en_o); end
    endtask

    task automatic test_power_up();
        logic [3:0] e_ce, e_rn;
        logic       e_bz;
        bus_a.req_i = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            e_ce = {3'b000, k >= 3};
            e_rn = {3'b000, k >= 7};
            e_bz = (k >= 3) && (k <= 6);
            nchecks++; if (bus_a.clk_en_o !== e_ce) begin
                nerr++; $display("FAIL pu_clk_en edge %0d: got %b want %b", k, bus_a.clk_en_o, e_ce); end
            nchecks++; if (bus_a.rst_n_o !== e_rn || bus_a.ack_o !== e_rn) begin
                nerr++; $display("FAIL pu_rst_ack edge %0d: got %b/%b want %b", k, bus_a.rst_n_o, bus_a.ack_o, e_rn); end
            nchecks++; if (bus_a.busy_o !== e_bz) begin
                nerr++; $display("FAIL pu_busy edge %0d: got %b want %b", k, bus_a.busy_o, e_bz); end
        end
    endtask

    task automatic test_power_down();
        logic [3:0] e_ce, e_rn;
        logic       e_bz;
        bus_a.req_i = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            e_ce = {3'b000, k < 7};
            e_rn = {3'b000, k < 3};
            e_bz = (k >= 3) && (k <= 6);
            nchecks++; if (bus_a.clk_en_o !== e_ce) begin
                nerr++; $display("FAIL pd_clk_en edge %0d: got %b want %b", k, bus_a.clk_en_o, e_ce); end
            nchecks++; if (bus_a.rst_n_o !== e_rn || bus_a.ack_o !== e_rn) begin
                nerr++; $display("FAIL pd_rst_ack edge %0d: got %b/%b want %b", k, bus_a.rst_n_o, bus_a.ack_o, e_rn); end
            nchecks++; if (bus_a.busy_o !== e_bz) begin
                nerr++; $display("FAIL pd_busy edge %0d: got %b want %b", k, bus_a.busy_o, e_bz); end
        end
    endtask

    task automatic test_sw_rst();
        logic [3:0] e_rn;
        // Pulse while OFF must be ignored.
        bus_a.sw_rst_i = 4'b0010;
        tick(1);
        bus_a.sw_rst_i = 4'b0000;
        tick(1);
        nchecks++; if (bus_a.clk_en_o !== 4'b0000 || bus_a.busy_o !== 1'b0) begin
            nerr++; $display("FAIL swrst_off_ignored: got %b/%b want 0000/0", bus_a.clk_en_o, bus_a.busy_o); end
        bus_a.req_i = 4'b0010;
        tick(8);
        nchecks++; if (bus_a.ack_o !== 4'b0010 || bus_a.rst_n_o !== 4'b0010) begin
            nerr++; $display("FAIL swrst_run: got %b/%b want 0010/0010", bus_a.ack_o, bus_a.rst_n_o); end
        bus_a.sw_rst_i = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            // Second pulse lands in SWRST and must not extend the reset.
            bus_a.sw_rst_i = (k == 1) ? 4'b0010 : 4'b0000;
            e_rn = (k <= 2) ? 4'b0000 : 4'b0010;
            nchecks++; if (bus_a.rst_n_o !== e_rn || bus_a.ack_o !== e_rn) begin
                nerr++; $display("FAIL swrst_pulse edge %0d: got %b/%b want %b", k, bus_a.rst_n_o, bus_a.ack_o, e_rn); end
            nchecks++; if (bus_a.clk_en_o !== 4'b0010) begin
                nerr++; $display("FAIL swrst_clk edge %0d: got %b want 0010", k, bus_a.clk_en_o); end
        end
        bus_a.req_i = 4'b0000;
        tick(8);
        nchecks++; if (bus_a.clk_en_o !== 4'b0000) begin
            nerr++; $display("FAIL swrst_down: got %b want 0000", bus_a.clk_en_o); end
    endtask

    task automatic test_abort_reissue();
        logic [3:0] e_ce;
        bus_a.req_i = 4'b0001;
        tick(4);
        bus_a.req_i = 4'b0000;
        for (int k = 5; k <= 12; k++) begin
            tick(1);
            e_ce = {3'b000, k < 11};
            nchecks++; if (bus_a.clk_en_o !== e_ce || bus_a.busy_o !== e_ce[0]) begin
                nerr++; $display("FAIL abort_clk edge %0d: got %b/%b want %b", k, bus_a.clk_en_o, bus_a.busy_o, e_ce); end
            nchecks++; if (bus_a.rst_n_o !== 4'b0000 || bus_a.ack_o !== 4'b0000) begin
                nerr++; $display("FAIL abort_rst edge %0d: got %b/%b want 0000", k, bus_a.rst_n_o, bus_a.ack_o); end
        end
        bus_a.req_i = 4'b0001;
        tick(8);
        nchecks++; if (bus_a.ack_o !== 4'b0001) begin
            nerr++; $display("FAIL reissue_run: got %b want 0001", bus_a.ack_o); end
        bus_a.req_i = 4'b0000;
        tick(3);
        bus_a.req_i = 4'b0001;
        for (int k = 4; k <= 8; k++) begin
            tick(1);
            e_ce = {3'b000, k != 7};
            nchecks++; if (bus_a.clk_en_o !== e_ce || bus_a.busy_o !== e_ce[0]) begin
                nerr++; $display("FAIL reissue_clk edge %0d: got %b/%b want %b", k, bus_a.clk_en_o, bus_a.busy_o, e_ce); end
            nchecks++; if (bus_a.rst_n_o !== 4'b0000) begin
                nerr++; $display("FAIL reissue_rst edge %0d: got %b want 0000", k, bus_a.rst_n_o); end
        end
        tick(4);
        nchecks++; if (bus_a.ack_o !== 4'b0001 || bus_a.rst_n_o !== 4'b0001) begin
            nerr++; $display("FAIL reissue_rerun: got %b/%b want 0001", bus_a.ack_o, bus_a.rst_n_o); end
        bus_a.req_i = 4'b0000;
        tick(8);
    endtask

    task automatic test_chain();
        logic [3:0] e_ack, e_ce;
        bus_b.req_i = 4'b1111;
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            for (int i = 0; i < 4; i++) begin
                e_ack[i] = (k >= 7 + 5 * i);
                e_ce[i]  = (k >= 3 + 5 * i);
            end
            nchecks++; if (bus_b.ack_o !== e_ack || bus_b.clk_en_o !== e_ce) begin
                nerr++; $display("FAIL chain_up edge %0d: got %b/%b want %b/%b", k, bus_b.ack_o, bus_b.clk_en_o, e_ack, e_ce); end
        end
        bus_b.req_i = 4'b0000;
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            for (int i = 0; i < 4; i++) begin
                e_ack[i] = (k < 3 + 5 * (3 - i));
                e_ce[i]  = (k < 7 + 5 * (3 - i));
            end
            nchecks++; if (bus_b.ack_o !== e_ack || bus_b.clk_en_o !== e_ce) begin
                nerr++; $display("FAIL chain_down edge %0d: got %b/%b want %b/%b", k, bus_b.ack_o, bus_b.clk_en_o, e_ack, e_ce); end
        end
    endtask

    task automatic test_scan_async();
        bus_a.req_i = 4'b1111;
        tick(8);
        nchecks++; if (bus_a.ack_o !== 4'b1111) begin
            nerr++; $display("FAIL scan_setup: got %b want 1111", bus_a.ack_o); end
        scan_mode = 1'b1; scan_rstn = 1'b0;
        #1;
        nchecks++; if (bus_a.clk_en_o !== 4'b1111 || bus_a.rst_n_o !== 4'b0000 || bus_a.ack_o !== 4'b1111) begin
            nerr++; $display("FAIL scan_rstn0: got %b/%b/%b want 1111/0000/1111", bus_a.clk_en_o, bus_a.rst_n_o, bus_a.ack_o); end
        scan_rstn = 1'b1;
        #1;
        nchecks++; if (bus_b.clk_en_o !== 4'b1111 || bus_b.rst_n_o !== 4'b1111 || bus_b.ack_o !== 4'b0000) begin
            nerr++; $display("FAIL scan_off_ch: got %b/%b/%b want 1111/1111/0000", bus_b.clk_en_o, bus_b.rst_n_o, bus_b.ack_o); end
        scan_mode = 1'b0;
        tick(1);
        #2;
        rstn = 1'b0;
        #1;
        nchecks++; if ({bus_a.clk_en_o, bus_a.rst_n_o, bus_a.ack_o, bus_a.busy_o} !== 13'd0) begin
            nerr++; $display("FAIL async_rst: got %b want 0", {bus_a.clk_en_o, bus_a.rst_n_o, bus_a.ack_o, bus_a.busy_o}); end
        tick(2);
        nchecks++; if (bus_a.clk_en_o !== 4'b0000 || bus_a.busy_o !== 1'b0) begin
            nerr++; $display("FAIL async_hold: got %b/%b want 0000/0", bus_a.clk_en_o, bus_a.busy_o); end
        bus_a.req_i = 4'b0000;
        rstn = 1'b1;
        tick(3);
        nchecks++; if (bus_a.clk_en_o !== 4'b0000 || bus_a.ack_o !== 4'b0000) begin
            nerr++; $display("FAIL async_release: got %b/%b want 0000", bus_a.clk_en_o, bus_a.ack_o); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down();
        test_sw_rst();
        test_abort_reissue();
        test_chain();
        test_scan_async();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
